imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width in bits; only 32 is supported.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 8, meaning the instruction memory word-address width.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum idle cycles allowed between accepted bytes while loading.
REQ-004 The module SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port load_req, input, 1 bit: a one-cycle pulse that starts a load.
REQ-007 The module SHALL have port byte_valid, input, 1 bit: the byte source presents byte_data.
REQ-008 The module SHALL have port byte_data, input, 8 bits: stream byte.
REQ-009 The module SHALL have port byte_ready, output, 1 bit: the loader can accept a byte.
REQ-010 The module SHALL have port wr_en, output, 1 bit: instruction memory write strobe.
REQ-011 The module SHALL have port wr_addr, output, ADDR_WIDTH bits: word address.
REQ-012 The module SHALL have port wr_data, output, DATA_WIDTH bits: assembled instruction word.
REQ-013 The module SHALL have port core_rst, output, 1 bit: holds the RISC-V core in reset.
REQ-014 The module SHALL have port busy, output, 1 bit: a load is in progress.
REQ-015 The module SHALL have port done, output, 1 bit: the last load succeeded; sticky.
REQ-016 The module SHALL have port error, output, 1 bit: the last load failed; sticky.

Function
REQ-017 A byte SHALL be accepted on a rising clk edge only when byte_valid=1 and byte_ready=1.
REQ-018 The stream format SHALL be: LEN_LO, LEN_HI (16-bit word count N), then N words of 4 bytes each, least-significant byte first, then one checksum byte.
REQ-019 The checksum byte SHALL equal the XOR of all 4N payload bytes; the length bytes are excluded.
REQ-020 The FSM SHALL have the states IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR.
REQ-021 Transitions: IDLE/DONE/ERR go to LEN_LO on load_req; LEN_LO goes to LEN_HI on accept; LEN_HI goes to DATA on accept if 0<N<=2^ADDR_WIDTH, to CHECK if N=0, and to ERR if N>2^ADDR_WIDTH.
REQ-022 Transitions: DATA goes to CHECK on acceptance of the 4th byte of word N-1; CHECK goes to DONE on a matching accepted byte and to ERR on a mismatch.
REQ-023 byte_ready SHALL be 1 exactly in LEN_LO, LEN_HI, DATA and CHECK.
REQ-024 busy SHALL be 1 in the same four states.
REQ-025 wr_en SHALL pulse high for exactly one cycle, the cycle after the 4th byte of each word is accepted.
REQ-026 wr_addr SHALL start at 0 and increment by 1 after each write.
REQ-027 wr_data SHALL be {b3,b2,b1,b0} and SHALL be held stable while wr_en=1.
REQ-028 core_rst SHALL be 1 in every state except DONE, and SHALL drop on the cycle DONE is entered.
REQ-029 A timeout counter SHALL clear on each accepted byte and on state entry.
REQ-030 If the timeout counter reaches TIMEOUT_CYCLES while busy=1, the FSM SHALL go to ERR.
REQ-031 load_req while busy=1 SHALL be ignored.
REQ-032 load_req in DONE SHALL reassert core_rst the next cycle and clear done.
REQ-033 Entering LEN_LO SHALL clear done, error, the checksum, wr_addr and the byte index.
REQ-034 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-035 At N=2^ADDR_WIDTH, the final wr_addr SHALL be 2^ADDR_WIDTH-1, and the address wrap to 0 SHALL NOT produce an extra write.

Reset
REQ-036 While rst=1: state=IDLE, core_rst=1, and byte_ready, busy, wr_en, done, error, wr_addr, wr_data, the counters and the checksum SHALL all be 0.
REQ-037 rst asserted mid-load SHALL abort the load immediately with no further wr_en; words already written SHALL remain in memory.

Structure
REQ-038 The FSM state encoding, the stream-format byte counts and the checksum definition SHALL live in the shared package riscv_pkg.
REQ-039 One sub-module, loader_timeout (a resettable down-counter with an expired flag), SHALL be used.
REQ-040 The checksum and word-assembly logic SHALL remain inline in imem_loader.

Verification
REQ-041 Stream N=2, words 0x00500093 and 0x00100113, correct checksum: wr_en at addresses 0 and 1 with those words; done=1, core_rst=0.
REQ-042 Same stream with the checksum XORed by 0x01: both writes occur; error=1, core_rst stays 1, done=0.
REQ-043 N=0 followed by checksum 0x00: no wr_en; done=1.
REQ-044 LEN bytes giving N=257 with ADDR_WIDTH=8: ERR right after LEN_HI, no wr_en.
REQ-045 Stall of TIMEOUT_CYCLES after byte 5: error=1.
REQ-046 load_req pulses while busy: ignored.
REQ-047 rst pulse after word 0 is written: IDLE, no further writes, core_rst=1.
REQ-048 Random byte_valid gaps shorter than the timeout: the same write sequence as the gap-free stream.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// boot-stream framing byte counts and the payload checksum.
package riscv_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } load_state_t;

    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CSUM_BYTES = 1;

    // Checksum is a running XOR over payload bytes only; length bytes excluded.
    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] b);
        return csum ^ b;
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle timer: reloadable down-counter whose expired flag is raised
// once CYCLES enabled cycles pass without a reload.
module loader_timeout #(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    // Loaded with CYCLES-1 so that terminal count lands after CYCLES idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= W'(CYCLES - 1);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes it word by word into instruction memory while holding the core in reset.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no load since reset; core held in reset
// LEN_LO   | waiting for low byte of word count
// LEN_HI   | waiting for high byte of word count; range check on accept
// DATA     | assembling 4-byte words, one memory write per word
// CHECK    | waiting for the checksum byte
// DONE     | load succeeded; core released from reset
// ERR      | bad length, checksum mismatch or timeout; core held in reset
module imem_loader
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    load_state_t state, state_nxt;

    logic [15:0]           len;
    logic [1:0]            byte_idx;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [7:0]            csum;
    logic [DATA_WIDTH-1:0] word_buf;

    logic        accept;
    logic        start;
    logic        last_word;
    logic        tmo_clr;
    logic        tmo_expired;
    logic [16:0] len_new;

    assign busy       = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CHECK);
    assign byte_ready = busy;
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERR);
    assign core_rst   = (state != S_DONE);

    assign accept    = byte_valid && byte_ready;
    assign start     = load_req && !busy;
    assign len_new   = {1'b0, byte_data, len[7:0]};
    assign last_word = (17'(word_idx) == (17'(len) - 17'd1)) &&
                       (byte_idx == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_req) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    if (len_new == 17'd0)          state_nxt = S_CHECK;
                    else if (len_new > MAX_WORDS)  state_nxt = S_ERR;
                    else                           state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && last_word) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (accept) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (busy && !accept && tmo_expired) state_nxt = S_ERR;
    end

    assign tmo_clr = accept || (state_nxt != state);

    loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (busy),
        .expired (tmo_expired)
    );

    // Word assembly, checksum and write strobe; address is captured per write
    // so the last write of a full-depth image leaves wr_addr at the top word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            csum     <= '0;
            word_buf <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                len      <= '0;
                byte_idx <= '0;
                word_idx <= '0;
                csum     <= '0;
                wr_addr  <= '0;
            end else if (accept) begin
                case (state)
                    S_LEN_LO: len[7:0]  <= byte_data;
                    S_LEN_HI: len[15:8] <= byte_data;
                    S_DATA: begin
                        csum                   <= csum_next(csum, byte_data);
                        word_buf[8*byte_idx +: 8] <= byte_data;
                        byte_idx               <= byte_idx + 2'd1;
                        if (byte_idx == 2'(WORD_BYTES - 1)) begin
                            wr_en    <= 1'b1;
                            wr_data  <= {byte_data, word_buf[23:0]};
                            wr_addr  <= word_idx[ADDR_WIDTH-1:0];
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes
// plus per-scenario checks of status outputs.
module tb_imem_loader;
    localparam int AW = 8;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_req = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready, wr_en, core_rst, busy, done, error;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;

    logic [AW+31:0] exp_q[$];
    logic [31:0]    words[$];

    always #5 clk = ~clk;

    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .core_rst(core_rst),
        .busy(busy), .done(done), .error(error)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            logic [AW+31:0] e;
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0h data=%08h, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%0h data=%08h, expected addr=%0h data=%08h",
                             wr_addr, wr_data, e[AW+31:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit acc;
        acc = 0;
        if (maxgap > 0) tick($urandom_range(maxgap, 0));
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1;
                acc = 1;
            end
        end
        byte_valid = 1'b0;
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL byte_accept_timeout byte=%02h not accepted within 50 cycles", b);
        end
    endtask

    // Sends length, payload from `words`, checksum^cx; pushes expected writes.
    task automatic send_stream(input int n, input logic [7:0] cx, input int maxgap, input int pulse_at);
        logic [7:0]  bq[$];
        logic [7:0]  cs;
        logic [15:0] n16;
        logic [31:0] w;
        cs  = 8'h00;
        n16 = 16'(n);
        bq.push_back(n16[7:0]);
        bq.push_back(n16[15:8]);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int b = 0; b < 4; b++) begin
                bq.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        bq.push_back(cs ^ cx);
        for (int j = 0; j < bq.size(); j++) begin
            if (j == pulse_at) start_load();
            if (j >= 2 && j < 2 + 4*n && ((j - 2) % 4) == 3)
                exp_q.push_back({AW'((j - 2) / 4), words[(j - 2) / 4]});
            send_byte(bq[j], maxgap);
        end
    endtask

    task automatic check_status(input string nm, input logic e_done, input logic e_err,
                                input logic e_crst, input logic e_busy);
        checks++;
        if ({done, error, core_rst, busy} !== {e_done, e_err, e_crst, e_busy}) begin
            errors++;
            $display("FAIL %s got done/err/core_rst/busy=%b%b%b%b expected %b%b%b%b", nm,
                     done, error, core_rst, busy, e_done, e_err, e_crst, e_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if ({core_rst, byte_ready, busy, wr_en, done, error} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got crst/rdy/busy/wr/done/err=%b%b%b%b%b%b expected 100000",
                     core_rst, byte_ready, busy, wr_en, done, error);
        end
        checks++;
        if (wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_bus got addr=%0h data=%08h expected 0 0", wr_addr, wr_data);
        end
        rst = 1'b0;
        tick(2);
        check_status("idle_after_reset", 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_basic();
        int c0;
        c0 = wr_count;
        words = '{32'h00500093, 32'h00100113};
        start_load();
        check_status("loading", 1'b0, 1'b0, 1'b1, 1'b1);
        send_stream(2, 8'h00, 0, -1);
        check_status("basic_done", 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wr_count - c0 !== 2) begin
            errors++;
            $display("FAIL basic_writes got %0d expected 2", wr_count - c0);
        end
    endtask

    task automatic test_back_to_back_random_gaps();
        int c0;
        c0 = wr_count;
        start_load();
        check_status("reload_from_done", 1'b0, 1'b0, 1'b1, 1'b1);
        send_stream(2, 8'h00, 10, -1);
        check_status("gaps_done", 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wr_count - c0 !== 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL gaps_writes got %0d pending=%0d expected 2 pending=0", wr_count - c0, exp_q.size());
        end
    endtask

    task automatic test_bad_csum();
        int c0;
        c0 = wr_count;
        start_load();
        send_stream(2, 8'h01, 0, -1);
        check_status("bad_csum", 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (wr_count - c0 !== 2) begin
            errors++;
            $display("FAIL bad_csum_writes got %0d expected 2", wr_count - c0);
        end
    endtask

    task automatic test_zero_len();
        int c0;
        c0 = wr_count;
        start_load();
        send_stream(0, 8'h00, 0, -1);
        tick(2);
        check_status("zero_len", 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wr_count !== c0) begin
            errors++;
            $display("FAIL zero_len_writes got %0d expected 0", wr_count - c0);
        end
    endtask

    task automatic test_too_long();
        int c0;
        c0 = wr_count;
        start_load();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check_status("too_long", 1'b0, 1'b1, 1'b1, 1'b0);
        tick(3);
        checks++;
        if (wr_count !== c0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL too_long_quiet got writes=%0d ready=%b expected 0 0", wr_count - c0, byte_ready);
        end
    endtask

    task automatic test_timeout();
        start_load();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        tick(TO - 1);
        check_status("before_timeout", 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1);
        check_status("timeout", 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_load_req_busy();
        int c0;
        c0 = wr_count;
        words = '{32'hDEADBEEF, 32'h12345678, 32'hA5A5_0F0F};
        start_load();
        send_stream(3, 8'h00, 0, 5);
        check_status("busy_req_ignored", 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wr_count - c0 !== 3) begin
            errors++;
            $display("FAIL busy_req_writes got %0d expected 3", wr_count - c0);
        end
    endtask

    task automatic test_full_len();
        int c0;
        c0 = wr_count;
        words = {};
        for (int i = 0; i < 256; i++) words.push_back($urandom);
        start_load();
        send_stream(256, 8'h00, 0, -1);
        tick(2);
        check_status("full_len_done", 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wr_count - c0 !== 256 || wr_addr !== 8'hFF) begin
            errors++;
            $display("FAIL full_len got writes=%0d addr=%0h expected 256 ff", wr_count - c0, wr_addr);
        end
    endtask

    task automatic test_rst_mid();
        int c0;
        words = '{32'hCAFEF00D, 32'h0BADC0DE};
        start_load();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) exp_q.push_back({8'h00, words[0]});
            send_byte(words[0][8*b +: 8], 0);
        end
        tick(2);
        c0 = wr_count;
        rst = 1'b1;
        #1;
        check_status("rst_mid", 1'b0, 1'b0, 1'b1, 1'b0);
        tick(2);
        rst = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        tick(10);
        byte_valid = 1'b0;
        check_status("after_rst_idle", 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (wr_count !== c0 || wr_addr !== '0) begin
            errors++;
            $display("FAIL rst_mid_writes got extra=%0d addr=%0h expected 0 0", wr_count - c0, wr_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back_random_gaps();
        test_bad_csum();
        test_zero_len();
        test_too_long();
        test_timeout();
        test_load_req_busy();
        test_full_len();
        test_rst_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got pending=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
